stream_arbiter: RTL and testbench
=================================

Name: stream_arbiter

Overview:
- Merges two byte-record streams into the 16-bit word write path that feeds fifo_sync in the clk_i domain.
  - Source 0: usb_capture output.
  - Source 1: status/marker records, e.g. trigger, speed change, overflow notices.
- Grants whole records round-robin and never interleaves bytes of two records.
- Packs bytes low-first into 16-bit words.
- Pads a dangling half-word on an explicit flush or after an idle timeout, so the host always receives complete data.

Parameters:
- FLUSH_TIMEOUT, 1024: idle cycles with a pending half-word before an automatic pad. Range 2..65535.
- PAD_BYTE, 8'hff: byte used as the high half of a padded word.

Ports:
- clk_i, input, 1: the only clock (t_usb_clk domain).
- reset_i, input, 1: synchronous, active-high reset.
- s0_data_i, input, 8: source 0 byte.
- s0_valid_i, input, 1: source 0 byte valid.
- s0_last_i, input, 1: source 0 byte is the last byte of its record.
- s0_ack_o, output, 1: source 0 byte consumed this cycle.
- s1_data_i, input, 8: source 1 byte.
- s1_valid_i, input, 1: source 1 byte valid.
- s1_last_i, input, 1: source 1 byte is the last byte of its record.
- s1_ack_o, output, 1: source 1 byte consumed this cycle.
- flush_i, input, 1: single-cycle pulse requesting a pad of a pending half-word.
- wr_data_o, output, 16: word to FIFO; {high byte, low byte}.
- wr_en_o, output, 1: word write strobe.
- wr_ready_i, input, 1: FIFO can accept a word.
- grant_o, output, 2: one-hot current grant; 2'b00 when idle.
- busy_o, output, 1: a grant is active, a half-word is pending, or a flush is pending.

Behaviour:
- Reset values: state IDLE, grant_o=0, half_valid_r=0, flush_pend_r=0, timeout counter=0, last_grant_r=1 (so source 0 wins first). Combinationally, every ack and wr_en_o is 0 while reset_i is high.
- Reset mid-record: the partial record and pending half-word are discarded, with no write and no pad.
- States: IDLE, G0, G1.
- IDLE:
  - Only one source valid: grant it.
  - Both valid: grant the source other than last_grant_r.
  - Neither valid: stay in IDLE.
  - The grant takes effect on the next cycle.
- G0/G1:
  - On an acked byte with last=1, choose the next grant combinationally with the same rule, excluding nothing. The next record therefore starts the following cycle with no bubble.
  - If neither source is valid at that point, go to IDLE.
  - last_grant_r updates on every grant.
- Handshake: sX_ack_o = granted_X && sX_valid_i && (!half_valid_r || wr_ready_i). Data is taken only on ack. A source must hold data, valid and last stable until it is acked.
- Packing (byte accepted):
  - If half_valid_r=0: latch the byte into lo_r and set half_valid_r.
  - Else: wr_en_o=1 and wr_data_o={byte, lo_r} in the same cycle, and half_valid_r clears.
  - Write latency for the second byte is 0 cycles (combinational strobe, as fifo_sync expects).
- Packing does not reset per record. Records pack contiguously, and a word may span a record boundary.
- flush_i: sets flush_pend_r on the cycle it is high. flush_pend_r clears when the pad is written, or immediately if half_valid_r=0 (no write is issued).
- Timeout counter:
  - Increments each cycle with half_valid_r=1 and no ack; saturates at FLUSH_TIMEOUT.
  - Clears on any ack or on a pad.
- Pad condition: state IDLE, half_valid_r=1, (flush_pend_r or counter==FLUSH_TIMEOUT), and wr_ready_i=1.
  - Result: wr_en_o=1, wr_data_o={PAD_BYTE, lo_r}, half_valid_r clears, flush_pend_r clears, counter clears.
- Pads are never inserted while a grant is active. A flush arriving mid-record waits for the record end.
- Pad and new-grant collision in IDLE: the pad writes this cycle, and the new grant is issued this cycle as normal (taking effect next cycle, per IDLE). A byte is never acked in the same cycle as a pad.
- wr_ready_i low:
  - A second byte is not acked, and that source stalls.
  - A first byte is still accepted when half_valid_r=0.
  - A pad waits.
- Round-robin fairness: with both sources continuously valid, grants alternate per record.

Test Plan:
- Source 0 sends record AA,BB,CC,DD (last on DD), wr_ready_i=1 -> wr_en_o pulses twice: 16'hBBAA then 16'hDDCC; s0_ack_o high 4 consecutive cycles; grant_o=01 then 00.
- Both sources valid; s0 record 11,22 and s1 record 33 (each with last), repeated -> grant order 0,1,0,1; no bubble between records; words 16'h2211, 16'h1133, 16'h3322; no interleaving within a record.
- Single byte 5A then idle, FLUSH_TIMEOUT=8 -> after 8 idle cycles wr_data_o=16'hFF5A with one wr_en_o pulse; busy_o falls the next cycle.
- flush_i pulsed mid-record (s1 record 01,02,03; pulse after 01) -> no pad until 03 is acked; then 16'h0201 is written, followed by 16'hFF03 once IDLE.
- wr_ready_i=0 with half_valid_r=1 and s0 valid -> s0_ack_o=0 and no wr_en_o; raising wr_ready_i -> ack and write in the same cycle.
- reset_i asserted after the first byte of a 3-byte record -> grant_o=00, busy_o=0, and no write or pad is ever emitted for the discarded byte.

Source files
------------

// File: rtl/stream_arbiter.sv
// Round-robin merge of two byte-record streams into the 16-bit FIFO write path.
// Bytes pack low-first; a dangling half-word is padded on flush or idle timeout.
module stream_arbiter #(
    parameter int unsigned FLUSH_TIMEOUT = 1024,
    parameter logic [7:0]  PAD_BYTE      = 8'hff
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  s0_data_i,
    input  logic        s0_valid_i,
    input  logic        s0_last_i,
    output logic        s0_ack_o,
    input  logic [7:0]  s1_data_i,
    input  logic        s1_valid_i,
    input  logic        s1_last_i,
    output logic        s1_ack_o,
    input  logic        flush_i,
    output logic [15:0] wr_data_o,
    output logic        wr_en_o,
    input  logic        wr_ready_i,
    output logic [1:0]  grant_o,
    output logic        busy_o
);

    localparam int unsigned      CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLUSH_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last_grant;
    logic             w_last_grant_next;
    logic             r_rec_start;
    logic             r_half_valid;
    logic [7:0]       r_lo;
    logic             r_flush_pend;
    logic [CNT_W-1:0] r_cnt;

    logic       w_room;
    logic       w_ack0;
    logic       w_ack1;
    logic       w_ack;
    logic       w_pad;
    logic       w_rearb;
    logic       w_any_valid;
    logic       w_pick_src;
    logic [7:0] w_byte;

    // Handshake: a second byte needs FIFO room, a first byte only fills lo_r.
    assign w_room = !r_half_valid || wr_ready_i;
    assign w_ack0 = !reset_i && (r_state == ST_G0) && s0_valid_i && w_room;
    assign w_ack1 = !reset_i && (r_state == ST_G1) && s1_valid_i && w_room;
    assign w_ack  = w_ack0 || w_ack1;
    assign w_byte = w_ack1 ? s1_data_i : s0_data_i;

    assign w_pad = !reset_i && (r_state == ST_IDLE) && r_half_valid
                   && (r_flush_pend || (r_cnt == CNT_MAX)) && wr_ready_i;

    // Round-robin pick: when both are valid the source not granted last wins.
    assign w_any_valid = s0_valid_i || s1_valid_i;
    assign w_pick_src  = (s0_valid_i && s1_valid_i) ? !r_last_grant : s1_valid_i;

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_rearb           = 1'b0;
        case (r_state)
            ST_IDLE: w_rearb = 1'b1;
            // A fresh grant whose source has nothing to send is released at once.
            ST_G0:   w_rearb = (w_ack0 && s0_last_i) || (r_rec_start && !s0_valid_i);
            ST_G1:   w_rearb = (w_ack1 && s1_last_i) || (r_rec_start && !s1_valid_i);
            default: w_rearb = 1'b1;
        endcase
        if (w_rearb) begin
            if (w_any_valid) begin
                w_state_next      = w_pick_src ? ST_G1 : ST_G0;
                w_last_grant_next = w_pick_src;
            end else begin
                w_state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_rec_start  <= 1'b0;
            r_half_valid <= 1'b0;
            r_lo         <= 8'h00;
            r_flush_pend <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;

            if (w_rearb)
                r_rec_start <= 1'b1;
            else if (w_ack)
                r_rec_start <= 1'b0;

            if (w_ack) begin
                if (r_half_valid) begin
                    r_half_valid <= 1'b0;
                end else begin
                    r_lo         <= w_byte;
                    r_half_valid <= 1'b1;
                end
            end else if (w_pad) begin
                r_half_valid <= 1'b0;
            end

            if (w_ack || w_pad)
                r_cnt <= '0;
            else if (r_half_valid && (r_cnt != CNT_MAX))
                r_cnt <= r_cnt + CNT_W'(1);

            // A flush is only resolved in IDLE so a mid-record request waits for the record end.
            if (w_pad)
                r_flush_pend <= 1'b0;
            else if (flush_i)
                r_flush_pend <= 1'b1;
            else if ((r_state == ST_IDLE) && !r_half_valid)
                r_flush_pend <= 1'b0;
        end
    end

    assign s0_ack_o  = w_ack0;
    assign s1_ack_o  = w_ack1;
    assign wr_en_o   = (w_ack && r_half_valid) || w_pad;
    assign wr_data_o = w_pad ? {PAD_BYTE, r_lo} : {w_byte, r_lo};
    assign busy_o    = (r_state != ST_IDLE) || r_half_valid || r_flush_pend;

    always_comb begin
        grant_o = 2'b00;
        case (r_state)
            ST_G0:   grant_o = 2'b01;
            ST_G1:   grant_o = 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed and randomized checks of stream_arbiter: packing, round-robin order,
// flush/timeout padding, backpressure and reset discard.
module tb_stream_arbiter;

    localparam int unsigned FT = 8;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [7:0]  s0_data_i, s1_data_i;
    logic        s0_valid_i, s0_last_i, s0_ack_o;
    logic        s1_valid_i, s1_last_i, s1_ack_o;
    logic        flush_i;
    logic [15:0] wr_data_o;
    logic        wr_en_o;
    logic        wr_ready_i;
    logic [1:0]  grant_o;
    logic        busy_o;

    stream_arbiter #(.FLUSH_TIMEOUT(FT), .PAD_BYTE(8'hFF)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .s0_data_i(s0_data_i), .s0_valid_i(s0_valid_i), .s0_last_i(s0_last_i), .s0_ack_o(s0_ack_o),
        .s1_data_i(s1_data_i), .s1_valid_i(s1_valid_i), .s1_last_i(s1_last_i), .s1_ack_o(s1_ack_o),
        .flush_i(flush_i), .wr_data_o(wr_data_o), .wr_en_o(wr_en_o), .wr_ready_i(wr_ready_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_mis = 0;

    // Pending bytes per source as {last, data}; the head is presented until acked.
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [15:0] wlog[$];
    logic [8:0]  alog[$];

    logic        s_ack0, s_ack1, s_wen, s_busy;
    logic [15:0] s_wdata;
    logic [1:0]  s_grant;
    logic [7:0]  s_adata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wget(input int i);
        if (i < wlog.size()) return wlog[i];
        return 16'hxxxx;
    endfunction

    // One clock: present queue heads, sample outputs mid-cycle, pop on ack.
    task automatic cyc();
        s0_valid_i = (q0.size() > 0);
        if (q0.size() > 0) {s0_last_i, s0_data_i} = q0[0];
        s1_valid_i = (q1.size() > 0);
        if (q1.size() > 0) {s1_last_i, s1_data_i} = q1[0];
        @(negedge clk_i);
        s_ack0  = s0_ack_o;
        s_ack1  = s1_ack_o;
        s_wen   = wr_en_o;
        s_wdata = wr_data_o;
        s_grant = grant_o;
        s_busy  = busy_o;
        s_adata = s_ack1 ? s1_data_i : s0_data_i;
        if (s_wen) wlog.push_back(s_wdata);
        if (s_ack0) alog.push_back({1'b0, s0_data_i});
        if (s_ack1) alog.push_back({1'b1, s1_data_i});
        @(posedge clk_i);
        #1;
        if (s_ack0) void'(q0.pop_front());
        if (s_ack1) void'(q1.pop_front());
    endtask

    task automatic reset_dut();
        reset_i = 1'b1;
        cyc();
        cyc();
        reset_i = 1'b0;
        q0.delete(); q1.delete(); wlog.delete(); alog.delete();
    endtask

    task automatic drain(input string tag, input int bound);
        logic done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            cyc();
            if (q0.size() == 0 && q1.size() == 0 && !s_busy) done = 1'b1;
        end
        chk(tag, done, 1'b1);
    endtask

    initial begin
        int f, l, na, ack_c, pad_c, nw, n0, n1, len;
        logic [1:0]  g_first;
        logic        bz_pad, bz_after, pend, got;
        logic [7:0]  eb[$];
        logic [15:0] ew[$];
        logic [7:0]  b;

        reset_i = 1'b1; flush_i = 1'b0; wr_ready_i = 1'b1;
        s0_data_i = '0; s0_valid_i = 1'b0; s0_last_i = 1'b0;
        s1_data_i = '0; s1_valid_i = 1'b0; s1_last_i = 1'b0;
        reset_dut();
        chk("rst_grant", s_grant, 2'b00);
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_wen", s_wen, 1'b0);

        // Single 4-byte record from source 0.
        q0 = '{{1'b0, 8'hAA}, {1'b0, 8'hBB}, {1'b0, 8'hCC}, {1'b1, 8'hDD}};
        f = -1; l = -1; na = 0; g_first = 2'bxx;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (s_ack0) begin
                if (f < 0) begin f = i; g_first = s_grant; end
                l = i; na++;
            end
        end
        chk("t1_nwords", wlog.size(), 2);
        chk("t1_w0", wget(0), 16'hBBAA);
        chk("t1_w1", wget(1), 16'hDDCC);
        chk("t1_nacks", na, 4);
        chk("t1_ack_span", l - f, 3);
        chk("t1_grant", g_first, 2'b01);
        chk("t1_grant_end", s_grant, 2'b00);

        // Round-robin between two always-valid sources, no bubble between records.
        reset_dut();
        q0 = '{{1'b0, 8'h11}, {1'b1, 8'h22}, {1'b0, 8'h11}, {1'b1, 8'h22}};
        q1 = '{{1'b1, 8'h33}, {1'b1, 8'h33}};
        f = -1; l = -1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (s_ack0 || s_ack1) begin
                if (f < 0) f = i;
                l = i;
            end
        end
        chk("t2_nwords", wlog.size(), 3);
        chk("t2_w0", wget(0), 16'h2211);
        chk("t2_w1", wget(1), 16'h1133);
        chk("t2_w2", wget(2), 16'h3322);
        chk("t2_ack_span", l - f, 5);
        chk("t2_nacks", alog.size(), 6);
        if (alog.size() == 6) begin
            chk("t2_a0", alog[0], {1'b0, 8'h11});
            chk("t2_a1", alog[1], {1'b0, 8'h22});
            chk("t2_a2", alog[2], {1'b1, 8'h33});
            chk("t2_a3", alog[3], {1'b0, 8'h11});
            chk("t2_a4", alog[4], {1'b0, 8'h22});
            chk("t2_a5", alog[5], {1'b1, 8'h33});
        end

        // Lone byte padded by idle timeout.
        wlog.delete();
        q0.push_back({1'b1, 8'h5A});
        ack_c = -1; pad_c = -1; nw = 0; bz_pad = 1'b0; bz_after = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (s_ack0) ack_c = i;
            if (s_wen) begin nw++; pad_c = i; bz_pad = s_busy; end
            if (pad_c >= 0 && i == pad_c + 1) bz_after = s_busy;
        end
        chk("t3_nwrites", nw, 1);
        chk("t3_word", wget(0), 16'hFF5A);
        chk("t3_delay", pad_c - ack_c, FT + 1);
        chk("t3_busy_at_pad", bz_pad, 1'b1);
        chk("t3_busy_fall", bz_after, 1'b0);

        // Flush mid-record waits for the record end.
        wlog.delete();
        q1 = '{{1'b0, 8'h01}, {1'b0, 8'h02}, {1'b1, 8'h03}};
        pend = 1'b0; ack_c = -1; pad_c = -1;
        for (int i = 0; i < 14; i++) begin
            flush_i = pend;
            pend = 1'b0;
            cyc();
            flush_i = 1'b0;
            if (s_ack1 && s_adata == 8'h01) pend = 1'b1;
            if (s_ack1 && s_adata == 8'h03) ack_c = i;
            if (s_wen && s_wdata[15:8] == 8'hFF) pad_c = i;
        end
        chk("t4_nwords", wlog.size(), 2);
        chk("t4_w0", wget(0), 16'h0201);
        chk("t4_w1", wget(1), 16'hFF03);
        chk("t4_pad_after_end", (pad_c > ack_c) && (ack_c >= 0), 1'b1);
        chk("t4_pad_by_flush", (pad_c - ack_c) <= FT, 1'b1);

        // Flush with nothing pending writes nothing and clears.
        wlog.delete();
        flush_i = 1'b1; cyc(); flush_i = 1'b0;
        cyc(); cyc();
        chk("t4b_busy", s_busy, 1'b0);
        chk("t4b_nwords", wlog.size(), 0);

        // Backpressure on the second byte.
        wlog.delete();
        q0 = '{{1'b0, 8'h71}, {1'b1, 8'h72}};
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin cyc(); got = s_ack0; end
        chk("t5_first_ack", got, 1'b1);
        wr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_stall_ack", s_ack0, 1'b0);
            chk("t5_stall_wen", s_wen, 1'b0);
        end
        wr_ready_i = 1'b1;
        cyc();
        chk("t5_resume_ack", s_ack0, 1'b1);
        chk("t5_resume_wen", s_wen, 1'b1);
        chk("t5_resume_data", s_wdata, 16'h7271);
        drain("t5_drain", 20);

        // First byte accepted without FIFO room; the pad then waits for room.
        wlog.delete();
        wr_ready_i = 1'b0;
        q0.push_back({1'b1, 8'h81});
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin cyc(); got = s_ack0; end
        chk("t5b_ack_no_room", got, 1'b1);
        for (int i = 0; i < 15; i++) cyc();
        chk("t5b_pad_waits", wlog.size(), 0);
        wr_ready_i = 1'b1;
        cyc();
        chk("t5b_pad_wen", s_wen, 1'b1);
        chk("t5b_pad_data", s_wdata, 16'hFF81);

        // Reset after the first byte discards it.
        drain("t6_pre_drain", 20);
        q0 = '{{1'b0, 8'h91}, {1'b0, 8'h92}, {1'b1, 8'h93}};
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin cyc(); got = s_ack0; end
        chk("t6_first_ack", got, 1'b1);
        wlog.delete();
        reset_i = 1'b1;
        cyc();
        chk("t6_ack_in_reset", s_ack0, 1'b0);
        chk("t6_wen_in_reset", s_wen, 1'b0);
        reset_i = 1'b0;
        q0.delete();
        cyc();
        chk("t6_grant", s_grant, 2'b00);
        chk("t6_busy", s_busy, 1'b0);
        for (int i = 0; i < 20; i++) cyc();
        chk("t6_no_write", wlog.size(), 0);

        // Random records with random FIFO backpressure; expected words from a stream model.
        reset_dut();
        n0 = 12; n1 = 9;
        eb.delete(); ew.delete();
        for (int r = 0; r < n0; r++) begin
            if (r < n0) begin
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom);
                    q0.push_back({k == len - 1, b});
                    eb.push_back(b);
                end
            end
            if (r < n1) begin
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom);
                    q1.push_back({k == len - 1, b});
                    eb.push_back(b);
                end
            end
        end
        for (int k = 0; k < eb.size(); k += 2)
            ew.push_back({(k + 1 < eb.size()) ? eb[k + 1] : 8'hFF, eb[k]});
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            wr_ready_i = ($urandom_range(0, 3) != 0);
            cyc();
            if (q0.size() == 0 && q1.size() == 0 && !s_busy) got = 1'b1;
        end
        wr_ready_i = 1'b1;
        chk("rnd_done", got, 1'b1);
        chk("rnd_nwords", wlog.size(), ew.size());
        for (int k = 0; k < ew.size(); k++)
            chk($sformatf("rnd_w%0d", k), wget(k), ew[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
